// File: rtl/alu_if.sv
// Request/result bundle between the reservation station and the integer ALU.
// Clock, reset, rdy and rollback stay as plain scalar ports.
interface alu_if;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;

    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        alu_result_jump;
    logic [31:0] alu_result_pc;

    modport master (
        output alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        input  alu_result, alu_result_rob_pos, alu_result_val,
               alu_result_jump, alu_result_pc
    );

    modport slave (
        input  alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        output alu_result, alu_result_rob_pos, alu_result_val,
               alu_result_jump, alu_result_pc
    );
endinterface

// File: rtl/alu.sv
// Single-cycle RV32I integer ALU with branch/jump resolution.
// One op per cycle; results broadcast the cycle after acceptance.
module alu (
    input  logic  clk,
    input  logic  rst,
    input  logic  rdy,
    input  logic  rollback,
    alu_if.slave  bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0]  rob_pos;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } res_t;

    logic [31:0] v1, v2, imm, pc, op2, pc4, pc_imm;
    logic [4:0]  shamt;
    logic        take;
    res_t        res_n, res_q;
    logic        vld_q;

    assign v1     = bus.alu_val1;
    assign v2     = bus.alu_val2;
    assign imm    = bus.alu_imm;
    assign pc     = bus.alu_pc;
    assign op2    = (bus.alu_opcode == OPC_OP) ? v2 : imm;
    assign shamt  = op2[4:0];
    assign pc4    = pc + 32'd4;
    assign pc_imm = pc + imm;

    always_comb begin
        res_n         = '0;
        res_n.rob_pos = bus.alu_rob_pos;
        res_n.pc      = pc4;
        take          = 1'b0;
        case (bus.alu_opcode)
            OPC_OP_IMM, OPC_OP: begin
                case (bus.alu_funct3)
                    // funct7 selects sub only for register-register ops
                    3'b000:  res_n.val = (bus.alu_opcode == OPC_OP && bus.alu_funct7) ? v1 - op2 : v1 + op2;
                    3'b001:  res_n.val = v1 << shamt;
                    3'b010:  res_n.val = {31'b0, $signed(v1) < $signed(op2)};
                    3'b011:  res_n.val = {31'b0, v1 < op2};
                    3'b100:  res_n.val = v1 ^ op2;
                    3'b101:  res_n.val = bus.alu_funct7 ? 32'($signed(v1) >>> shamt) : v1 >> shamt;
                    3'b110:  res_n.val = v1 | op2;
                    default: res_n.val = v1 & op2;
                endcase
            end
            OPC_LUI:   res_n.val = imm;
            OPC_AUIPC: res_n.val = pc_imm;
            OPC_JAL: begin
                res_n.val  = pc4;
                res_n.jump = 1'b1;
                res_n.pc   = pc_imm;
            end
            OPC_JALR: begin
                res_n.val  = pc4;
                res_n.jump = 1'b1;
                res_n.pc   = (v1 + imm) & ~32'd1;
            end
            OPC_BRANCH: begin
                case (bus.alu_funct3)
                    3'b000:  take = (v1 == v2);
                    3'b001:  take = (v1 != v2);
                    3'b100:  take = ($signed(v1) < $signed(v2));
                    3'b101:  take = ($signed(v1) >= $signed(v2));
                    3'b110:  take = (v1 < v2);
                    3'b111:  take = (v1 >= v2);
                    default: take = 1'b0;
                endcase
                res_n.jump = take;
                res_n.pc   = take ? pc_imm : pc4;
            end
            default: ;
        endcase
    end

    // rollback only kills the valid pulse; payload registers keep stale data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            res_q <= '0;
        end else if (rollback) begin
            vld_q <= 1'b0;
        end else if (rdy) begin
            vld_q <= bus.alu_en;
            if (bus.alu_en)
                res_q <= res_n;
        end
    end

    assign bus.alu_result         = vld_q;
    assign bus.alu_result_rob_pos = res_q.rob_pos;
    assign bus.alu_result_val     = res_q.val;
    assign bus.alu_result_jump    = res_q.jump;
    assign bus.alu_result_pc      = res_q.pc;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed corner cases, freeze/rollback/reset, random stream.
module tb_alu;
    typedef struct {
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, rdy, rollback;
    alu_if bus();

    alu dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus));

    always #5 clk = ~clk;

    int   errs = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t cur;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rob, input exp_t e);
        bus.alu_en      = 1'b1;
        bus.alu_opcode  = opc;
        bus.alu_funct3  = f3;
        bus.alu_funct7  = f7;
        bus.alu_val1    = v1;
        bus.alu_val2    = v2;
        bus.alu_imm     = imm;
        bus.alu_pc      = pc;
        bus.alu_rob_pos = rob;
        cur             = e;
    endtask

    // one clock; an op that will be accepted goes on the scoreboard first
    task automatic step(input string tag);
        bit   acc;
        exp_t e;
        acc = rdy && bus.alu_en && !rollback && !rst;
        if (acc) sb.push_back(cur);
        @(posedge clk);
        #1;
        if (acc) begin
            chk({tag, ".vld"}, 32'(bus.alu_result), 32'd1);
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, ".rob"},  32'(bus.alu_result_rob_pos), 32'(e.rob));
                chk({tag, ".val"},  bus.alu_result_val, e.val);
                chk({tag, ".jump"}, 32'(bus.alu_result_jump), 32'(e.jump));
                chk({tag, ".pc"},   bus.alu_result_pc, e.pc);
            end
        end else if (rollback || rdy) begin
            chk({tag, ".vld0"}, 32'(bus.alu_result), 32'd0);
        end
    endtask

    // reference model, written as a flat decode independent of the RTL layout
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                                   input logic [31:0] pc, input logic [3:0] rob);
        exp_t r;
        logic [31:0] b;
        logic signed [31:0] sv1, sb2;
        logic t;
        r = '{rob, 32'd0, 1'b0, pc + 32'd4};
        b = (opc == 7'b0110011) ? v2 : imm;
        sv1 = v1;
        sb2 = b;
        if (opc == 7'b0010011 || opc == 7'b0110011) begin
            if (f3 == 3'b000)      r.val = (opc == 7'b0110011 && f7) ? v1 + ~b + 32'd1 : v1 + b;
            else if (f3 == 3'b001) r.val = v1 << b[4:0];
            else if (f3 == 3'b010) r.val = (sv1 < sb2) ? 32'd1 : 32'd0;
            else if (f3 == 3'b011) r.val = (v1 < b) ? 32'd1 : 32'd0;
            else if (f3 == 3'b100) r.val = v1 ^ b;
            else if (f3 == 3'b101) r.val = f7 ? 32'(sv1 >>> b[4:0]) : v1 >> b[4:0];
            else if (f3 == 3'b110) r.val = v1 | b;
            else                   r.val = v1 & b;
        end else if (opc == 7'b0110111) begin
            r.val = imm;
        end else if (opc == 7'b0010111) begin
            r.val = pc + imm;
        end else if (opc == 7'b1101111) begin
            r.val = pc + 32'd4; r.jump = 1'b1; r.pc = pc + imm;
        end else if (opc == 7'b1100111) begin
            r.val = pc + 32'd4; r.jump = 1'b1; r.pc = {v1[31:1] + imm[31:1] + 31'(v1[0] & imm[0]), 1'b0};
        end else if (opc == 7'b1100011) begin
            sb2 = v2;
            case (f3)
                3'b000:  t = v1 == v2;
                3'b001:  t = v1 != v2;
                3'b100:  t = sv1 < sb2;
                3'b101:  t = !(sv1 < sb2);
                3'b110:  t = v1 < v2;
                3'b111:  t = !(v1 < v2);
                default: t = 1'b0;
            endcase
            r.jump = t;
            if (t) r.pc = pc + imm;
        end
        return r;
    endfunction

    logic [6:0] opcs [9];

    initial begin
        logic [6:0]  o;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b, im, p;
        logic [3:0]  rb;
        opcs = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        bus.alu_en = 1'b0; bus.alu_opcode = '0; bus.alu_funct3 = '0; bus.alu_funct7 = 1'b0;
        bus.alu_val1 = '0; bus.alu_val2 = '0; bus.alu_imm = '0; bus.alu_pc = '0; bus.alu_rob_pos = '0;
        #1;
        chk("rst.vld",  32'(bus.alu_result), 32'd0);
        chk("rst.rob",  32'(bus.alu_result_rob_pos), 32'd0);
        chk("rst.val",  bus.alu_result_val, 32'd0);
        chk("rst.jump", 32'(bus.alu_result_jump), 32'd0);
        chk("rst.pc",   bus.alu_result_pc, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        drive(7'b0110011, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h40, 4'd5, '{4'd5, 32'h80000000, 1'b0, 32'h44});
        step("add");
        bus.alu_en = 1'b0;
        step("idle");

        drive(7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'h24, 32'd0, 32'h0, 4'd1, '{4'd1, 32'hF8000000, 1'b0, 32'h4});
        step("sra");
        drive(7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h24, 32'd0, 32'h0, 4'd2, '{4'd2, 32'h08000000, 1'b0, 32'h4});
        step("srl");
        drive(7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h100, 4'd3, '{4'd3, 32'd0, 1'b1, 32'hF0});
        step("blt");
        drive(7'b1100011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h100, 4'd4, '{4'd4, 32'd0, 1'b0, 32'h104});
        step("bltu");
        drive(7'b1100111, 3'b000, 1'b0, 32'h1001, 32'd0, 32'd2, 32'h200, 4'd6, '{4'd6, 32'h204, 1'b1, 32'h1002});
        step("jalr");
        drive(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h10, 4'd7, '{4'd7, 32'hFFFFFFFE, 1'b0, 32'h14});
        step("sub");
        drive(7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h10, 4'd8, '{4'd8, 32'd4, 1'b0, 32'h14});
        step("addi_f7");
        drive(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hABCDE000, 32'h20, 4'd9, '{4'd9, 32'hABCDE000, 1'b0, 32'h24});
        step("lui");
        drive(7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h20, 4'd10, '{4'd10, 32'h1020, 1'b0, 32'h24});
        step("auipc");
        drive(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFFFFF8, 32'h30, 4'd11, '{4'd11, 32'h34, 1'b1, 32'h28});
        step("jal");
        drive(7'b1100011, 3'b010, 1'b0, 32'd1, 32'd1, 32'h40, 32'h30, 4'd12, '{4'd12, 32'd0, 1'b0, 32'h34});
        step("br_undef");
        drive(7'b0000011, 3'b010, 1'b0, 32'd9, 32'd9, 32'h40, 32'h50, 4'd13, '{4'd13, 32'd0, 1'b0, 32'h54});
        step("unlisted");

        // freeze with rdy low, then rollback while still frozen
        drive(7'b0010011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'd0, 32'h0000FFFF, 32'h60, 4'd14, '{4'd14, 32'hF0F00F0F, 1'b0, 32'h64});
        step("frz_op");
        rdy = 1'b0;
        drive(7'b0110011, 3'b110, 1'b0, 32'h1, 32'h2, 32'd0, 32'h70, 4'd2, '{4'd2, 32'h3, 1'b0, 32'h74});
        for (int i = 0; i < 3; i++) begin
            step("frz");
            chk("frz.vld", 32'(bus.alu_result), 32'd1);
            chk("frz.val", bus.alu_result_val, 32'hF0F00F0F);
            chk("frz.rob", 32'(bus.alu_result_rob_pos), 32'd14);
            chk("frz.pc",  bus.alu_result_pc, 32'h64);
        end
        rollback = 1'b1;
        step("rb_frz");
        rollback = 1'b0; rdy = 1'b1;
        bus.alu_en = 1'b0;
        step("post_rb");

        // rollback discards the op presented on the same edge
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h80, 4'd1, '{4'd1, 32'd2, 1'b0, 32'h84});
        rollback = 1'b1;
        step("rb_disc");
        rollback = 1'b0;

        // asynchronous reset while the pulse is high
        drive(7'b0110011, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'h90, 4'd3, '{4'd3, 32'h0F, 1'b0, 32'h94});
        step("pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("arst.vld", 32'(bus.alu_result), 32'd0);
        chk("arst.val", bus.alu_result_val, 32'd0);
        chk("arst.pc",  bus.alu_result_pc, 32'd0);
        chk("arst.rob", 32'(bus.alu_result_rob_pos), 32'd0);
        #1 rst = 1'b0;
        drive(7'b0010011, 3'b001, 1'b0, 32'h1, 32'd0, 32'd31, 32'hA0, 4'd15, '{4'd15, 32'h80000000, 1'b0, 32'hA4});
        step("post_rst");

        // random stream, back-to-back with occasional bubbles
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(3) == 0) begin
                bus.alu_en = 1'b0;
            end else begin
                o  = opcs[$urandom_range(8)];
                f3 = 3'($urandom);
                f7 = 1'($urandom);
                a  = $urandom;
                b  = ($urandom_range(3) == 0) ? a : $urandom;
                im = $urandom;
                p  = $urandom & 32'hFFFFFFFC;
                rb = 4'($urandom);
                drive(o, f3, f7, a, b, im, p, rb, model(o, f3, f7, a, b, im, p, rb));
            end
            step("rnd");
        end
        bus.alu_en = 1'b0;
        step("drain");
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port rdy, input, 1 bit: global ready; low freezes all state.
REQ-004 The block SHALL have port rollback, input, 1 bit: mispredict flush, synchronous.
REQ-005 The block SHALL have port alu_en, input, 1 bit: op valid from reservation station.
REQ-006 The block SHALL have ports alu_opcode (7), alu_funct3 (3) and alu_funct7 (1, instr bit 30), all inputs: decoded fields.
REQ-007 The block SHALL have ports alu_val1, alu_val2 and alu_imm, inputs, 32 bits each: rs1 value, rs2 value, immediate (already sign-extended).
REQ-008 The block SHALL have port alu_pc, input, 32 bits: instruction PC.
REQ-009 The block SHALL have port alu_rob_pos, input, 4 bits: destination ROB slot.
REQ-010 The block SHALL have port alu_result, output, 1 bit: broadcast-valid pulse.
REQ-011 The block SHALL have ports alu_result_rob_pos (4 bits) and alu_result_val (32 bits), outputs: tag and value.
REQ-012 The block SHALL have ports alu_result_jump (1 bit) and alu_result_pc (32 bits), outputs: control transfer taken, and next PC.

Function
REQ-013 Latency SHALL be exactly one cycle: op accepted on edge N when alu_en=1 and rdy=1; all result outputs registered and valid after edge N.
REQ-014 The block SHALL accept one op per cycle, never stall, and have no back-pressure output.
REQ-015 alu_result SHALL be 1 for exactly the cycle after acceptance; an edge with rdy=1 and alu_en=0 SHALL clear it.
REQ-016 While rdy=0 and rollback=0, every output register SHALL hold its value and inputs SHALL be ignored.
REQ-017 rollback=1 on an edge SHALL clear alu_result regardless of rdy and alu_en, and SHALL discard the op presented that cycle.
REQ-018 OP-IMM (0010011): op2=alu_imm; funct3 000 add, 010 signed less-than, 011 unsigned less-than, 100 xor, 110 or, 111 and, 001 sll, 101 srl (funct7=0) / sra (funct7=1); funct7 is ignored for 000.
REQ-019 OP (0110011): op2=alu_val2; same funct3 map as REQ-018, except 000 with funct7=1 is sub.
REQ-020 Shift amount SHALL be op2[4:0]; compare results SHALL zero-extend to 32 bits; arithmetic SHALL wrap modulo 2^32.
REQ-021 LUI (0110111): val=imm. AUIPC (0010111): val=pc+imm. Both SHALL produce jump=0 and alu_result_pc=pc+4.
REQ-022 JAL (1101111): val=pc+4, jump=1, alu_result_pc=pc+imm.
REQ-023 JALR (1100111): val=pc+4, jump=1, alu_result_pc=(val1+imm) with bit 0 forced to 0.
REQ-024 BRANCH (1100011): funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu on val1 vs val2; jump=condition; alu_result_pc = pc+imm if taken, else pc+4; val=0.
REQ-025 An undefined BRANCH funct3 or an unlisted opcode SHALL still broadcast, with val=0, jump=0 and alu_result_pc=pc+4.
REQ-026 alu_result_rob_pos SHALL equal the accepted alu_rob_pos.
REQ-027 No result SHALL be dropped or duplicated; back-to-back ops SHALL produce consecutive broadcast cycles in acceptance order.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, set alu_result=0, alu_result_jump=0, alu_result_rob_pos=0, alu_result_val=0 and alu_result_pc=0.
REQ-029 An op accepted on the edge where rst deasserts SHALL be processed normally; rst asserted mid-broadcast SHALL kill the pulse at once.

Verification
REQ-030 The bench SHALL cover: OP add val1=0x7FFFFFFF, val2=1, rob_pos=5 -> next cycle alu_result=1, val=0x80000000, rob_pos=5, jump=0; the following cycle alu_result=0.
REQ-031 The bench SHALL cover: OP funct3=101, funct7=1, val1=0x80000000, val2=0x24 -> val=0xF8000000; with funct7=0 -> val=0x08000000.
REQ-032 The bench SHALL cover: BRANCH blt, val1=0xFFFFFFFF, val2=1, pc=0x100, imm=0xFFFFFFF0 -> jump=1, alu_result_pc=0xF0; same operands with bltu -> jump=0, alu_result_pc=0x104.
REQ-033 The bench SHALL cover: JALR pc=0x200, val1=0x1001, imm=2 -> val=0x204, jump=1, alu_result_pc=0x1002.
REQ-034 The bench SHALL cover: op accepted, then rdy=0 for 3 cycles -> all outputs frozen with alu_result=1; then rollback=1 while rdy=0 -> alu_result=0 after the edge.
REQ-035 The bench SHALL cover: rst pulsed between edges while alu_result=1 -> outputs zero before the next edge; alu_en=1 on the first edge after release -> normal result.
